ibex_rf_wport_arbiter: RTL and testbench



---
 rtl/ibex_pkg.sv | 26 ++
 rtl/ibex_rf_wr_fifo.sv | 63 ++++++
 rtl/ibex_rf_wport_arbiter.sv | 152 +++++++++++++++
 tb/tb_ibex_rf_wport_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared definitions for the register-file write path.
//   rf_wr_src_e : which producer owns the write port in a given cycle
//   rf_wr_req_t : one register-file write (destination + data)
//   rf_addr_writes() : x0 is hard-wired to zero, so a write to it is a no-op
package ibex_pkg;

  localparam int unsigned RfAddrW = 5;
  localparam int unsigned RfDataW = 32;

  typedef enum logic [1:0] {
    RF_WR_NONE,
    RF_WR_ID,
    RF_WR_LSU,
    RF_WR_ALT
  } rf_wr_src_e;

  typedef struct packed {
    logic [RfAddrW-1:0] waddr;
    logic [RfDataW-1:0] wdata;
  } rf_wr_req_t;

  function automatic logic rf_addr_writes(input logic [RfAddrW-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/ibex_rf_wr_fifo.sv
// Small synchronous FIFO of register-file write requests.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : enqueue push_data_i (dropped when full unless pop_i is set)
//   pop_i        : dequeue the head (ignored when empty)
//   full_o       : occupancy equals Depth
//   empty_o      : occupancy is zero
//   head_o       : oldest entry, valid whenever empty_o is low
module ibex_rf_wr_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  rf_wr_req_t push_data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output rf_wr_req_t head_o
);

  // Depth is a power of two, so the pointers wrap naturally.
  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  rf_wr_req_t      mem_q [Depth];

  logic push_ok, pop_ok;

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);

  // A push into a full FIFO is accepted when the head leaves the same cycle.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Head is read combinationally so an entry is arbitrable the cycle after its push.
  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/ibex_rf_wport_arbiter.sv
// Arbiter for the single register-file write port.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   id_*                         : ID/EX write request (valid/ready)
//   lsu_*                        : load response pulse, buffered in a FIFO (no ready)
//   alt_*                        : multi-cycle / coprocessor write request (valid/ready)
//   rf_we_o/rf_waddr_o/rf_wdata_o: registered register-file write port
//   lsu_fifo_full_o              : load FIFO is full
//   lsu_overflow_o               : sticky, a load response was lost
//   busy_o                       : FIFO non-empty or any request pending
// Priority: starved ALT > buffered load > ID > ALT.
module ibex_rf_wport_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned LsuFifoDepth = 2,
  parameter int unsigned AltMaxWait   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  output logic        id_ready_o,
  input  logic [4:0]  id_waddr_i,
  input  logic [31:0] id_wdata_i,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_waddr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        alt_valid_i,
  output logic        alt_ready_o,
  input  logic [4:0]  alt_waddr_i,
  input  logic [31:0] alt_wdata_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        lsu_fifo_full_o,
  output logic        lsu_overflow_o,
  output logic        busy_o
);

  localparam int unsigned CntW = $clog2(AltMaxWait + 1);

  rf_wr_req_t lsu_req, fifo_head, win_req;
  logic       fifo_full, fifo_empty, fifo_pop;
  rf_wr_src_e src;

  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            overflow_q, overflow_d;
  logic            we_q, we_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;

  always_comb begin
    lsu_req       = '0;
    lsu_req.waddr = lsu_waddr_i;
    lsu_req.wdata = lsu_wdata_i;
  end

  ibex_rf_wr_fifo #(
    .Depth (LsuFifoDepth)
  ) u_lsu_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (lsu_valid_i),
    .push_data_i (lsu_req),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  // Grant depends only on registered FIFO state and ID/ALT valids, so the
  // lsu_* inputs never reach an output combinationally.
  always_comb begin
    src = RF_WR_NONE;
    if (alt_valid_i && (starve_cnt_q == CntW'(AltMaxWait))) begin
      src = RF_WR_ALT;
    end else if (!fifo_empty) begin
      src = RF_WR_LSU;
    end else if (id_valid_i) begin
      src = RF_WR_ID;
    end else if (alt_valid_i) begin
      src = RF_WR_ALT;
    end
  end

  always_comb begin
    win_req = '0;
    unique case (src)
      RF_WR_ID: begin
        win_req.waddr = id_waddr_i;
        win_req.wdata = id_wdata_i;
      end
      RF_WR_LSU: win_req = fifo_head;
      RF_WR_ALT: begin
        win_req.waddr = alt_waddr_i;
        win_req.wdata = alt_wdata_i;
      end
      default: win_req = '0;
    endcase
  end

  assign id_ready_o  = (src == RF_WR_ID);
  assign alt_ready_o = (src == RF_WR_ALT);
  assign fifo_pop    = (src == RF_WR_LSU);

  // Counts consecutive denied ALT cycles; saturates so the forced win persists.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!alt_valid_i || alt_ready_o) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CntW'(AltMaxWait)) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end
  end

  // A drop happens only when the full FIFO is not popping this cycle.
  assign overflow_d = overflow_q | (lsu_valid_i & fifo_full & ~fifo_pop);

  // x0 writes still complete the handshake but never assert the write enable.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (src != RF_WR_NONE) begin
      we_d    = rf_addr_writes(win_req.waddr);
      waddr_d = win_req.waddr;
      wdata_d = win_req.wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
      overflow_q   <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      overflow_q   <= overflow_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign rf_we_o         = we_q;
  assign rf_waddr_o      = waddr_q;
  assign rf_wdata_o      = wdata_q;
  assign lsu_fifo_full_o = fifo_full;
  assign lsu_overflow_o  = overflow_q;
  assign busy_o          = ~fifo_empty | id_valid_i | alt_valid_i;

endmodule

// File: tb/tb_ibex_rf_wport_arbiter.sv
module tb_ibex_rf_wport_arbiter;

  localparam int DEPTH = 2;
  localparam int MAXW  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0, lsu_valid = 1'b0, alt_valid = 1'b0;
  logic [4:0]  id_waddr = '0, lsu_waddr = '0, alt_waddr = '0;
  logic [31:0] id_wdata = '0, lsu_wdata = '0, alt_wdata = '0;
  logic        id_ready, alt_ready, rf_we, full, ovf, busy;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  ibex_rf_wport_arbiter #(
    .LsuFifoDepth (DEPTH),
    .AltMaxWait   (MAXW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .id_valid_i      (id_valid),
    .id_ready_o      (id_ready),
    .id_waddr_i      (id_waddr),
    .id_wdata_i      (id_wdata),
    .lsu_valid_i     (lsu_valid),
    .lsu_waddr_i     (lsu_waddr),
    .lsu_wdata_i     (lsu_wdata),
    .alt_valid_i     (alt_valid),
    .alt_ready_o     (alt_ready),
    .alt_waddr_i     (alt_waddr),
    .alt_wdata_i     (alt_wdata),
    .rf_we_o         (rf_we),
    .rf_waddr_o      (rf_waddr),
    .rf_wdata_o      (rf_wdata),
    .lsu_fifo_full_o (full),
    .lsu_overflow_o  (ovf),
    .busy_o          (busy)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: queue of pending loads, wait counter, expected port state.
  logic [36:0] mq[$];
  int          m_wait;
  bit          m_ovf;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          m_g;   // 0 none, 1 ID, 2 LSU, 3 ALT

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_wait = 0;
    m_ovf  = 0;
    m_we   = 0;
    m_wa   = '0;
    m_wd   = '0;
    m_g    = 0;
  endtask

  // Drive one cycle's inputs and check every output against the model.
  task automatic step_a(input logic idv, input logic [4:0] ida, input logic [31:0] idd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad);
    id_valid = idv;  id_waddr = ida;  id_wdata = idd;
    lsu_valid = lv;  lsu_waddr = la;  lsu_wdata = ld;
    alt_valid = av;  alt_waddr = aa;  alt_wdata = ad;
    #2;
    if (av && m_wait == MAXW) m_g = 3;
    else if (mq.size() != 0)  m_g = 2;
    else if (idv)             m_g = 1;
    else if (av)              m_g = 3;
    else                      m_g = 0;
    chk("id_ready",  id_ready,  m_g == 1);
    chk("alt_ready", alt_ready, m_g == 3);
    chk("busy",      busy,      (mq.size() != 0) || idv || av);
    chk("full",      full,      mq.size() == DEPTH);
    chk("overflow",  ovf,       m_ovf);
    chk("rf_we",     rf_we,     m_we);
    chk("rf_waddr",  rf_waddr,  m_wa);
    chk("rf_wdata",  rf_wdata,  m_wd);
  endtask

  // Clock edge: advance the model by the spec rules.
  task automatic step_b();
    logic [36:0] h;
    @(posedge clk);
    case (m_g)
      1: begin m_we = (id_waddr != 0); m_wa = id_waddr; m_wd = id_wdata; end
      2: begin h = mq.pop_front(); m_wa = h[36:32]; m_wd = h[31:0]; m_we = (m_wa != 0); end
      3: begin m_we = (alt_waddr != 0); m_wa = alt_waddr; m_wd = alt_wdata; end
      default: m_we = 1'b0;
    endcase
    if (lsu_valid) begin
      if (mq.size() < DEPTH) mq.push_back({lsu_waddr, lsu_wdata});
      else m_ovf = 1;
    end
    if (!alt_valid || m_g == 3) m_wait = 0;
    else if (m_wait < MAXW) m_wait++;
    #1;
    if (m_g != 0)
      $display("[%0t] write src=%0d waddr=%0d wdata=0x%08h we=%0b", $time, m_g, m_wa, m_wd, m_we);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    id_valid = 0; lsu_valid = 0; alt_valid = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic idv; logic [4:0] ida; logic [31:0] idd;
    logic lv;  logic [4:0] la;  logic [31:0] ld;
    logic av;  logic [4:0] aa;  logic [31:0] ad;
    logic e_idr; logic e_altr; logic e_we; logic [4:0] e_wa; logic [31:0] e_wd;
  } tv_t;

  tv_t tv[9];

  initial begin
    logic [4:0]  alt_a;
    logic [31:0] alt_d;
    logic        id_p, alt_p;
    logic [4:0]  ra_id, ra_alt;
    logic [31:0] rd_id, rd_alt;

    tv[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
    tv[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    tv[2] = '{1'b1, 5'd7, 32'h22,       1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
    tv[3] = '{1'b1, 5'd8, 32'h33,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd7, 32'h22};
    tv[4] = '{1'b1, 5'd8, 32'h33,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd3, 32'h11};
    tv[5] = '{1'b1, 5'd0, 32'h55,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd8, 32'h33};
    tv[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 1'b0, 5'd0, 32'h55};
    tv[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd9, 32'h99};
    tv[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd9, 32'h99};

    model_reset();
    do_reset();

    // Reset state
    #2;
    chk("reset_rf_we",    rf_we,    0);
    chk("reset_rf_waddr", rf_waddr, 0);
    chk("reset_rf_wdata", rf_wdata, 0);
    chk("reset_full",     full,     0);
    chk("reset_overflow", ovf,      0);
    chk("reset_busy",     busy,     0);
    @(posedge clk);
    #1;

    // Directed vectors: lone ID, LSU/ID collision, x0 write, lone ALT
    for (int i = 0; i < 9; i++) begin
      step_a(tv[i].idv, tv[i].ida, tv[i].idd, tv[i].lv, tv[i].la, tv[i].ld,
             tv[i].av, tv[i].aa, tv[i].ad);
      chk($sformatf("tv%0d_id_ready", i),  id_ready,  tv[i].e_idr);
      chk($sformatf("tv%0d_alt_ready", i), alt_ready, tv[i].e_altr);
      chk($sformatf("tv%0d_rf_we", i),     rf_we,     tv[i].e_we);
      chk($sformatf("tv%0d_rf_waddr", i),  rf_waddr,  tv[i].e_wa);
      chk($sformatf("tv%0d_rf_wdata", i),  rf_wdata,  tv[i].e_wd);
      step_b();
    end

    // ID held with back-to-back LSU pulses: FIFO pops every cycle, never fills
    for (int i = 0; i < 4; i++) begin
      step_a(1'b1, 5'(20 + i), 32'h2000 + i, i < 3, 5'(12 + i), 32'h1200 + i,
             1'b0, 5'd0, 32'h0);
      chk("idheld_full", full, 0);
      step_b();
    end
    for (int i = 0; i < 2; i++) begin
      step_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step_b();
    end

    // Starvation: continuous LSU pulses with ALT held; forced wins fill the FIFO
    step_a(0, 0, 0, 1'b1, 5'd1, 32'd100, 0, 0, 0);
    step_b();
    alt_a = 5'd9;
    alt_d = 32'h900;
    for (int i = 1; i <= 10; i++) begin
      step_a(0, 0, 0, 1'b1, 5'(1 + i), 32'(100 + i), 1'b1, alt_a, alt_d);
      chk($sformatf("starve%0d_alt_ready", i), alt_ready, (i == 5) || (i == 10));
      chk($sformatf("starve%0d_full", i),      full,      i >= 6);
      chk($sformatf("starve%0d_overflow", i),  ovf,       0);
      step_b();
      if (i == 5) begin
        alt_a = 5'd10;
        alt_d = 32'hA00;
      end
    end
    step_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sticky_overflow", ovf,  1);
    chk("prefill_full",    full, 1);
    step_b();
    step_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sticky_overflow_drain", ovf, 1);

    // Reset with queued loads: nothing stale may be written afterwards
    do_reset();
    #2;
    chk("midrst_rf_we",    rf_we, 0);
    chk("midrst_busy",     busy,  0);
    chk("midrst_full",     full,  0);
    chk("midrst_overflow", ovf,   0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      step_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("postrst_no_write", rf_we, 0);
      step_b();
    end

    // Randomised traffic against the model; ID/ALT hold requests until granted
    id_p = 0; alt_p = 0;
    ra_id = '0; rd_id = '0; ra_alt = '0; rd_alt = '0;
    for (int c = 0; c < 400; c++) begin
      if (!id_p) begin
        id_p  = ($urandom_range(0, 1) == 1);
        ra_id = 5'($urandom_range(0, 31));
        rd_id = $urandom;
      end
      if (!alt_p) begin
        alt_p  = ($urandom_range(0, 2) == 0);
        ra_alt = 5'($urandom_range(0, 31));
        rd_alt = $urandom;
      end
      step_a(id_p, ra_id, rd_id, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom,
             alt_p, ra_alt, rd_alt);
      step_b();
      if (m_g == 1) id_p = 0;
      if (m_g == 3) alt_p = 0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
